// File: rtl/pending_encoder_32to5.sv
// pending_encoder_32to5: collects one-hot request lines into a pending register
// and offers the index of the winning request over a valid/ready handshake.
// Each completed transfer retires the bit that was served.
// Selection is lowest-index-first by default. Define PENDING_ENC_ROUND_ROBIN_EN
// to select round-robin starting just after the last granted index.
module pending_encoder_32to5 (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic [31:0] set_mask,
  input  logic        en,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [4:0]  out_index,
  output logic [31:0] pending,
  output logic [5:0]  pending_count
);

  localparam int unsigned N  = 32;
  localparam int unsigned IW = 5;
  localparam int unsigned CW = 6;

  logic [N-1:0]  pending_q, pending_d;
  logic          out_valid_q, out_valid_d;
  logic [IW-1:0] out_index_q, out_index_d;
  logic [CW-1:0] pending_count_q, pending_count_d;

  logic          xfer_c;
  logic [N-1:0]  grant_oh_c;
  logic [N-1:0]  nxt_c;
  logic [IW-1:0] sel_c;
  logic [CW-1:0] popcnt_c;

  // Handshake, retirement of the served bit, and merge of new requests (set wins)
  always_comb begin
    xfer_c     = out_valid_q & out_ready & en;
    grant_oh_c = '0;
    if (xfer_c) grant_oh_c = N'(1) << out_index_q;
    nxt_c      = (pending_q & ~grant_oh_c) | set_mask;
  end

  // Population count of the next pending vector
  always_comb begin
    popcnt_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      popcnt_c = popcnt_c + CW'(nxt_c[i]);
    end
  end

`ifdef PENDING_ENC_ROUND_ROBIN_EN
  logic [IW-1:0] last_grant_q, last_grant_d;
  logic [IW-1:0] start_c;
  logic          found_c;

  // Remember the index of the most recent transfer
  always_comb begin
    last_grant_d = last_grant_q;
    if (xfer_c) last_grant_d = out_index_q;
  end

  // Round-robin search from the slot after the last grant, wrapping 31->0
  always_comb begin
    start_c = last_grant_d + IW'(1);
    sel_c   = '0;
    found_c = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found_c && nxt_c[IW'(start_c + IW'(i))]) begin
        sel_c   = IW'(start_c + IW'(i));
        found_c = 1'b1;
      end
    end
  end

  // Last-grant register; reset to 31 so the first search begins at index 0
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) last_grant_q <= IW'(N - 1);
    else            last_grant_q <= last_grant_d;
  end
`else
  // Fixed priority: lowest set index wins, 0 when nothing is pending
  always_comb begin
    sel_c = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (nxt_c[i]) sel_c = IW'(i);
    end
  end
`endif

  // Next-state: freeze on en=0; hold the offered code while stalled
  always_comb begin
    pending_d       = pending_q;
    pending_count_d = pending_count_q;
    out_valid_d     = out_valid_q;
    out_index_d     = out_index_q;
    if (en) begin
      pending_d       = nxt_c;
      pending_count_d = popcnt_c;
      if (!(out_valid_q && !xfer_c)) begin
        out_valid_d = |nxt_c;
        out_index_d = sel_c;
      end
    end
  end

  // State registers
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      pending_q       <= '0;
      pending_count_q <= '0;
      out_valid_q     <= 1'b0;
      out_index_q     <= '0;
    end else begin
      pending_q       <= pending_d;
      pending_count_q <= pending_count_d;
      out_valid_q     <= out_valid_d;
      out_index_q     <= out_index_d;
    end
  end

  assign pending       = pending_q;
  assign pending_count = pending_count_q;
  assign out_valid     = out_valid_q;
  assign out_index     = out_index_q;

endmodule

// File: tb/tb_pending_encoder_32to5.sv
// Directed bench for pending_encoder_32to5: reset behaviour, a vector table of
// drain / stall / collision / enable / full cases, and hand-written sequences.
module tb_pending_encoder_32to5;

  logic        clock;
  logic        ctrl_reset;
  logic [31:0] set_mask;
  logic        en;
  logic        out_ready;
  logic        out_valid;
  logic [4:0]  out_index;
  logic [31:0] pending;
  logic [5:0]  pending_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] set_mask;
    logic        en;
    logic        out_ready;
    logic        exp_valid;
    logic [4:0]  exp_index;
    logic [31:0] exp_pending;
    logic [5:0]  exp_count;
  } vec_t;

  pending_encoder_32to5 dut (
    .clock         (clock),
    .ctrl_reset    (ctrl_reset),
    .set_mask      (set_mask),
    .en            (en),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_index     (out_index),
    .pending       (pending),
    .pending_count (pending_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic [4:0] idx,
                           input logic [31:0] p, input logic [5:0] c);
    check({tag, ".out_valid"},     32'(out_valid),     32'(v));
    check({tag, ".out_index"},     32'(out_index),     32'(idx));
    check({tag, ".pending"},       pending,            p);
    check({tag, ".pending_count"}, 32'(pending_count), 32'(c));
  endtask

  task automatic run_table(input string tag, input vec_t tbl[$]);
    foreach (tbl[k]) begin
      set_mask  = tbl[k].set_mask;
      en        = tbl[k].en;
      out_ready = tbl[k].out_ready;
      tick();
      check_all($sformatf("%s[%0d]", tag, k), tbl[k].exp_valid, tbl[k].exp_index,
                tbl[k].exp_pending, tbl[k].exp_count);
    end
  endtask

  task automatic do_reset();
    ctrl_reset = 1'b1;
    set_mask   = '0;
    en         = 1'b1;
    out_ready  = 1'b0;
    tick();
    ctrl_reset = 1'b0;
  endtask

  vec_t tbl[$];

  initial begin
    ctrl_reset = 1'b1;
    set_mask   = 32'hFFFF_FFFF;
    en         = 1'b1;
    out_ready  = 1'b0;

    // Reset held with all requests asserted: nothing accumulates
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("reset_hold", 1'b0, 5'd0, 32'h0, 6'd0);
    end
    ctrl_reset = 1'b0;
    tick();
    check_all("reset_release_full", 1'b1, 5'd0, 32'hFFFF_FFFF, 6'd32);

    // Asynchronous reset mid-handshake clears everything immediately
    out_ready = 1'b1;
    set_mask  = '0;
    #2;
    ctrl_reset = 1'b1;
    #1;
    check_all("async_reset", 1'b0, 5'd0, 32'h0, 6'd0);
    tick();
    ctrl_reset = 1'b0;
    check_all("async_reset_edge", 1'b0, 5'd0, 32'h0, 6'd0);

`ifndef PENDING_ENC_ROUND_ROBIN_EN
    tbl = '{
      // single request
      '{32'h0000_0400, 1'b1, 1'b1, 1'b1, 5'd10, 32'h0000_0400, 6'd1},
      '{32'h0000_0000, 1'b1, 1'b1, 1'b0, 5'd0,  32'h0000_0000, 6'd0},
      // fixed-priority drain 0, 4, 31
      '{32'h8000_0011, 1'b1, 1'b1, 1'b1, 5'd0,  32'h8000_0011, 6'd3},
      '{32'h0000_0000, 1'b1, 1'b1, 1'b1, 5'd4,  32'h8000_0010, 6'd2},
      '{32'h0000_0000, 1'b1, 1'b1, 1'b1, 5'd31, 32'h8000_0000, 6'd1},
      '{32'h0000_0000, 1'b1, 1'b1, 1'b0, 5'd0,  32'h0000_0000, 6'd0},
      // back-pressure holds 8 even when bit 2 arrives
      '{32'h0000_0100, 1'b1, 1'b0, 1'b1, 5'd8,  32'h0000_0100, 6'd1},
      '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 5'd8,  32'h0000_0100, 6'd1},
      '{32'h0000_0004, 1'b1, 1'b0, 1'b1, 5'd8,  32'h0000_0104, 6'd2},
      '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 5'd8,  32'h0000_0104, 6'd2},
      '{32'h0000_0000, 1'b1, 1'b1, 1'b1, 5'd2,  32'h0000_0004, 6'd1},
      '{32'h0000_0000, 1'b1, 1'b1, 1'b0, 5'd0,  32'h0000_0000, 6'd0},
      // set/retire collision on bit 5
      '{32'h0000_0060, 1'b1, 1'b0, 1'b1, 5'd5,  32'h0000_0060, 6'd2},
      '{32'h0000_0020, 1'b1, 1'b1, 1'b1, 5'd5,  32'h0000_0060, 6'd2},
      '{32'h0000_0000, 1'b1, 1'b1, 1'b1, 5'd6,  32'h0000_0040, 6'd1},
      '{32'h0000_0000, 1'b1, 1'b1, 1'b0, 5'd0,  32'h0000_0000, 6'd0},
      // en=0 freezes state and ignores set_mask/out_ready
      '{32'h0000_0003, 1'b1, 1'b0, 1'b1, 5'd0,  32'h0000_0003, 6'd2},
      '{32'h0000_0008, 1'b0, 1'b1, 1'b1, 5'd0,  32'h0000_0003, 6'd2},
      '{32'h0000_0000, 1'b1, 1'b1, 1'b1, 5'd1,  32'h0000_0002, 6'd1},
      '{32'h0000_0000, 1'b1, 1'b1, 1'b0, 5'd0,  32'h0000_0000, 6'd0},
      // full register
      '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 5'd0,  32'hFFFF_FFFF, 6'd32},
      '{32'h0000_0000, 1'b1, 1'b1, 1'b1, 5'd1,  32'hFFFF_FFFE, 6'd31},
      '{32'h0000_0000, 1'b1, 1'b1, 1'b1, 5'd2,  32'hFFFF_FFFC, 6'd30}
    };
    run_table("fixed", tbl);
`else
    do_reset();
    tbl = '{
      '{32'h8000_0003, 1'b1, 1'b0, 1'b1, 5'd0,  32'h8000_0003, 6'd3},
      '{32'h0000_0000, 1'b1, 1'b1, 1'b1, 5'd1,  32'h8000_0002, 6'd2},
      '{32'h4000_0001, 1'b1, 1'b1, 1'b1, 5'd30, 32'hC000_0001, 6'd3},
      '{32'h0000_0010, 1'b0, 1'b1, 1'b1, 5'd30, 32'hC000_0001, 6'd3},
      '{32'h0000_0000, 1'b1, 1'b1, 1'b1, 5'd31, 32'h8000_0001, 6'd2},
      '{32'h0000_0000, 1'b1, 1'b1, 1'b1, 5'd0,  32'h0000_0001, 6'd1},
      '{32'h0000_0000, 1'b1, 1'b1, 1'b0, 5'd0,  32'h0000_0000, 6'd0}
    };
    run_table("rr", tbl);
`endif

    // Final reset returns to the empty state
    do_reset();
    set_mask  = '0;
    out_ready = 1'b1;
    tick();
    check_all("final_empty", 1'b0, 5'd0, 32'h0, 6'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
